q3_fsm_array: RTL and testbench

//   NCH independent copies of the 5-state x/z sequence FSM (codes 000..100), each with its own

---
 rtl/q3_fsm_pkg.sv | 38 +++
 rtl/q3_fsm_ch.sv | 101 ++++++++++
 rtl/q3_fsm_array.sv | 41 ++++
 tb/tb_q3_fsm_array.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q3_fsm_pkg.sv
// Shared definitions for the x/z sequence FSM: state codes, transition table and output decode.
package q3_fsm_pkg;

  localparam int unsigned ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    S_A = 3'd0,
    S_B = 3'd1,
    S_C = 3'd2,
    S_D = 3'd3,
    S_E = 3'd4
  } q3_state_t;

  // Successor of a legal state for input x; illegal codes map to S_A.
  function automatic logic [ST_W-1:0] q3_next(input logic [ST_W-1:0] state, input logic x);
    logic [ST_W-1:0] nxt;
    nxt = S_A;
    case (state)
      S_A:     nxt = x ? S_B : S_A;
      S_B:     nxt = x ? S_E : S_B;
      S_C:     nxt = x ? S_B : S_C;
      S_D:     nxt = x ? S_C : S_B;
      S_E:     nxt = x ? S_E : S_D;
      default: nxt = S_A;
    endcase
    return nxt;
  endfunction

  // Moore output: high only in S_D and S_E.
  function automatic logic q3_z(input logic [ST_W-1:0] state);
    return (state == S_D) || (state == S_E);
  endfunction

  function automatic logic q3_legal(input logic [ST_W-1:0] state);
    return state <= S_E;
  endfunction

endpackage

// File: rtl/q3_fsm_ch.sv
// One channel of the sequence FSM: state, sticky illegal-code flag, saturating z counter,
// and an optional output register on z.
module q3_fsm_ch
  import q3_fsm_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned REG_Z = 0
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              en,
  input  logic              x,
  input  logic              ld,
  input  logic [ST_W-1:0]   ld_val,
  input  logic              clr,
  output logic [ST_W-1:0]   state,
  output logic              z,
  output logic [CNT_W-1:0]  z_cnt,
  output logic              err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_d;
  logic             err_q;
  logic             err_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             z_dec;
  logic             legal;

  // State register, err flag and counter.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= S_A;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: load beats recovery beats step; recovery wins over clr on err.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    legal   = q3_legal(state_q);

    if (ld) begin
      state_d = ld_val;
    end else if (!legal) begin
      state_d = S_A;
    end else if (en) begin
      state_d = q3_next(state_q, x);
    end

    if (clr) begin
      err_d = 1'b0;
    end
    if (!ld && !legal) begin
      err_d = 1'b1;
    end

    if (clr) begin
      cnt_d = '0;
    end else if (en && z_dec && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Output decode from the current state.
  always_comb begin
    z_dec = q3_z(state_q);
  end

  if (REG_Z != 0) begin : g_zreg
    logic z_q;

    // Registered z lags state by one cycle and ignores clr.
    always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
        z_q <= 1'b0;
      end else begin
        z_q <= z_dec;
      end
    end

    assign z = z_q;
  end else begin : g_zcomb
    assign z = z_dec;
  end

  assign state = state_q;
  assign z_cnt = cnt_q;
  assign err   = err_q;

endmodule

// File: rtl/q3_fsm_array.sv
// NCH independent sequence-FSM channels with per-lane status packed onto flat buses.
module q3_fsm_array
  import q3_fsm_pkg::*;
#(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned REG_Z = 0
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic [NCH-1:0]         en,
  input  logic [NCH-1:0]         x,
  input  logic [NCH-1:0]         ld,
  input  logic [ST_W*NCH-1:0]    ld_val,
  input  logic                   clr,
  output logic [ST_W*NCH-1:0]    state,
  output logic [NCH-1:0]         z,
  output logic [CNT_W*NCH-1:0]   z_cnt,
  output logic [NCH-1:0]         err
);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    q3_fsm_ch #(
      .CNT_W (CNT_W),
      .REG_Z (REG_Z)
    ) u_ch (
      .clk    (clk),
      .areset (areset),
      .en     (en[i]),
      .x      (x[i]),
      .ld     (ld[i]),
      .ld_val (ld_val[ST_W*i +: ST_W]),
      .clr    (clr),
      .state  (state[ST_W*i +: ST_W]),
      .z      (z[i]),
      .z_cnt  (z_cnt[CNT_W*i +: CNT_W]),
      .err    (err[i])
    );
  end

endmodule

// File: tb/tb_q3_fsm_array.sv
// Bench for q3_fsm_array: a default build and a CNT_W=2/REG_Z=1 build share one stimulus.
module tb_q3_fsm_array;

  localparam int unsigned NCH = 4;
  localparam int unsigned CWA = 8;
  localparam int unsigned CWB = 2;

  logic clk = 1'b0;
  logic areset;
  logic [NCH-1:0]     en, x, ld;
  logic [3*NCH-1:0]   ld_val;
  logic               clr;

  logic [3*NCH-1:0]   a_state, b_state;
  logic [NCH-1:0]     a_z, b_z, a_err, b_err;
  logic [CWA*NCH-1:0] a_cnt;
  logic [CWB*NCH-1:0] b_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model: per-channel state, err, counters for both widths, delayed z.
  int ms[NCH];
  bit merr[NCH];
  int mca[NCH];
  int mcb[NCH];
  bit mzr[NCH];
  int nx0[5] = '{0, 1, 2, 1, 3};
  int nx1[5] = '{1, 4, 1, 2, 4};

  q3_fsm_array #(.NCH(NCH), .CNT_W(CWA), .REG_Z(0)) dut_a (
    .clk(clk), .areset(areset), .en(en), .x(x), .ld(ld), .ld_val(ld_val), .clr(clr),
    .state(a_state), .z(a_z), .z_cnt(a_cnt), .err(a_err)
  );

  q3_fsm_array #(.NCH(NCH), .CNT_W(CWB), .REG_Z(1)) dut_b (
    .clk(clk), .areset(areset), .en(en), .x(x), .ld(ld), .ld_val(ld_val), .clr(clr),
    .state(b_state), .z(b_z), .z_cnt(b_cnt), .err(b_err)
  );

  always #5 clk = ~clk;

  function automatic bit zof(input int s);
    return (s == 3) || (s == 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      ms[i] = 0; merr[i] = 0; mca[i] = 0; mcb[i] = 0; mzr[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NCH; i++) begin
      int s;
      bit zz;
      s = ms[i];
      zz = zof(s);
      mzr[i] = zz;
      if (clr) begin
        mca[i] = 0; mcb[i] = 0;
      end else if (en[i] && zz) begin
        if (mca[i] < (1 << CWA) - 1) mca[i]++;
        if (mcb[i] < (1 << CWB) - 1) mcb[i]++;
      end
      if (clr) merr[i] = 0;
      if (!ld[i] && s > 4) merr[i] = 1;
      if (ld[i]) ms[i] = int'(ld_val[3*i +: 3]);
      else if (s > 4) ms[i] = 0;
      else if (en[i]) ms[i] = x[i] ? nx1[s] : nx0[s];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    en = '0; x = '0; ld = '0; ld_val = '0; clr = 1'b0;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if (int'(a_state[3*i +: 3]) !== ms[i] || int'(b_state[3*i +: 3]) !== ms[i]) begin
        errors++;
        $display("FAIL %s ch%0d state: got a=%0d b=%0d want %0d", tag, i,
                 a_state[3*i +: 3], b_state[3*i +: 3], ms[i]);
      end
      checks++;
      if (a_z[i] !== zof(ms[i]) || b_z[i] !== mzr[i]) begin
        errors++;
        $display("FAIL %s ch%0d z: got a=%0b b=%0b want a=%0b b=%0b", tag, i,
                 a_z[i], b_z[i], zof(ms[i]), mzr[i]);
      end
      checks++;
      if (int'(a_cnt[CWA*i +: CWA]) !== mca[i] || int'(b_cnt[CWB*i +: CWB]) !== mcb[i]) begin
        errors++;
        $display("FAIL %s ch%0d z_cnt: got a=%0d b=%0d want a=%0d b=%0d", tag, i,
                 a_cnt[CWA*i +: CWA], b_cnt[CWB*i +: CWB], mca[i], mcb[i]);
      end
      checks++;
      if (a_err[i] !== merr[i] || b_err[i] !== merr[i]) begin
        errors++;
        $display("FAIL %s ch%0d err: got a=%0b b=%0b want %0b", tag, i, a_err[i], b_err[i], merr[i]);
      end
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    areset = 1'b0;
    checks++;
    if (a_state !== '0 || b_state !== '0 || a_z !== '0 || b_z !== '0 ||
        a_cnt !== '0 || b_cnt !== '0 || a_err !== '0 || b_err !== '0) begin
      errors++;
      $display("FAIL reset: got a_state=%h a_cnt=%h a_err=%b b_state=%h b_cnt=%h b_err=%b want all 0",
               a_state, a_cnt, a_err, b_state, b_cnt, b_err);
    end
  endtask

  task automatic test_seq();
    int xs[5]  = '{1, 1, 0, 1, 1};
    int es[5]  = '{1, 4, 3, 2, 1};
    int eza[5] = '{0, 1, 1, 0, 0};
    int ezb[5] = '{0, 0, 1, 1, 0};
    idle_inputs();
    en[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      x[0] = xs[k][0];
      tick();
      checks++;
      if (int'(a_state[2:0]) !== es[k] || int'(b_state[2:0]) !== es[k]) begin
        errors++;
        $display("FAIL seq step%0d state0: got a=%0d b=%0d want %0d", k, a_state[2:0], b_state[2:0], es[k]);
      end
      checks++;
      if (int'(a_z[0]) !== eza[k] || int'(b_z[0]) !== ezb[k]) begin
        errors++;
        $display("FAIL seq step%0d z0: got a=%0b b=%0b want a=%0d b=%0d", k, a_z[0], b_z[0], eza[k], ezb[k]);
      end
    end
    checks++;
    if (a_cnt[7:0] !== 8'd2) begin
      errors++;
      $display("FAIL seq z_cnt0: got %0d want 2", a_cnt[7:0]);
    end
    check_model("seq");
  endtask

  task automatic test_hold();
    idle_inputs();
    en[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      x[1] = k[0];
      x[0] = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (a_state[5:3] !== 3'd0 || a_cnt[15:8] !== 8'd0 || b_state[5:3] !== 3'd0) begin
        errors++;
        $display("FAIL hold ch1: got state=%0d cnt=%0d want 0 0", a_state[5:3], a_cnt[15:8]);
      end
      check_model("hold");
    end
  endtask

  task automatic test_illegal();
    idle_inputs();
    ld[2] = 1'b1;
    ld_val[8:6] = 3'b110;
    tick();
    checks++;
    if (a_state[8:6] !== 3'b110 || a_z[2] !== 1'b0 || a_err[2] !== 1'b0) begin
      errors++;
      $display("FAIL illegal load: got state=%b z=%b err=%b want 110 0 0", a_state[8:6], a_z[2], a_err[2]);
    end
    ld = '0;
    tick();
    checks++;
    if (a_state[8:6] !== 3'b000 || a_err[2] !== 1'b1 || b_err[2] !== 1'b1) begin
      errors++;
      $display("FAIL illegal recover: got state=%b err=%b want 000 1", a_state[8:6], a_err[2]);
    end
    repeat (3) tick();
    checks++;
    if (a_err[2] !== 1'b1) begin
      errors++;
      $display("FAIL illegal sticky: got err=%b want 1", a_err[2]);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (a_err[2] !== 1'b0 || b_err[2] !== 1'b0) begin
      errors++;
      $display("FAIL illegal clr: got err a=%b b=%b want 0", a_err[2], b_err[2]);
    end
    check_model("illegal");
  endtask

  task automatic test_saturate();
    int eb[6] = '{1, 2, 3, 3, 3, 3};
    idle_inputs();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    ld[3] = 1'b1;
    ld_val[11:9] = 3'b100;
    tick();
    ld = '0;
    en[3] = 1'b1;
    x[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (int'(b_cnt[7:6]) !== eb[k] || int'(a_cnt[31:24]) !== k + 1 || a_state[11:9] !== 3'b100) begin
        errors++;
        $display("FAIL sat step%0d: got b_cnt=%0d a_cnt=%0d state=%b want %0d %0d 100", k,
                 b_cnt[7:6], a_cnt[31:24], a_state[11:9], eb[k], k + 1);
      end
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++;
    if (b_cnt[7:6] !== 2'd0 || a_cnt[31:24] !== 8'd0) begin
      errors++;
      $display("FAIL sat clr: got b=%0d a=%0d want 0", b_cnt[7:6], a_cnt[31:24]);
    end
    check_model("saturate");
  endtask

  task automatic test_async_reset();
    idle_inputs();
    ld[0] = 1'b1; ld_val[2:0] = 3'b100;
    ld[2] = 1'b1; ld_val[8:6] = 3'b111;
    tick();
    ld = '0; ld_val = '0;
    en[0] = 1'b1; x[0] = 1'b1;
    repeat (2) tick();
    check_model("pre_areset");
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if (a_state !== '0 || b_state !== '0 || a_z !== '0 || b_z !== '0 ||
        a_cnt !== '0 || b_cnt !== '0 || a_err !== '0 || b_err !== '0) begin
      errors++;
      $display("FAIL areset mid: got a_state=%h a_z=%b a_cnt=%h a_err=%b want all 0",
               a_state, a_z, a_cnt, a_err);
    end
    model_reset();
    @(negedge clk);
    areset = 1'b0;
    tick();
    checks++;
    if (a_state[2:0] !== 3'b001) begin
      errors++;
      $display("FAIL areset release: got state0=%b want 001", a_state[2:0]);
    end
    check_model("post_areset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en  = NCH'($urandom);
      x   = NCH'($urandom);
      ld  = '0;
      for (int i = 0; i < NCH; i++) ld[i] = ($urandom_range(0, 7) == 0);
      ld_val = (3*NCH)'($urandom);
      clr = ($urandom_range(0, 19) == 0);
      tick();
      check_model("random");
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_seq();
    test_hold();
    test_illegal();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
